// File: rtl/clk_sel_pkg.sv
// Shared types and defaults for the clock-select controller.
// Optional switch counter is enabled with `define CLK_SEL_SWITCH_CNT_EN.
package clk_sel_pkg;

  // Controller phases: idle and accepting, waiting for the mux handover,
  // and holding off new requests after a completed switch.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DWELL  = 2'd2
  } clk_sel_state_e;

  localparam int DEF_SETTLE_CYC = 8;
  localparam int DEF_DWELL_CYC  = 16;
  localparam int DEF_CNT_W      = 8;

  // Width of the shared settle/dwell down-counter: must hold the larger of
  // the two phase lengths.
  function automatic int timer_width(input int settle_cyc, input int dwell_cyc);
    int m;
    m = (settle_cyc > dwell_cyc) ? settle_cyc : dwell_cyc;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clk_sel_timer.sv
// Loadable down-counter shared by the SETTLE and DWELL phases.
// A load takes priority over a decrement; the count stops at zero.
module clk_sel_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load, otherwise decrement towards zero when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clk_sel_ctrl.sv
// Upstream controller for the glitch-free clock mux: accepts switch requests,
// drives the mux select, waits out the handover, pulses done, then enforces a
// dwell time before the next switch.
// Handshake: a request is taken on a rising edge where req_valid_i and
// req_ready_o are both high; req_sel_i is sampled only on that edge, and a
// request presented while req_ready_o is low is neither taken nor queued.
// Optional: `define CLK_SEL_SWITCH_CNT_EN adds a saturating switch counter
// output (switch_cnt_o) counting completed real switches.
module clk_sel_ctrl
  import clk_sel_pkg::*;
#(
`ifdef CLK_SEL_SWITCH_CNT_EN
  parameter int CNT_W      = DEF_CNT_W,
`endif
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int DWELL_CYC  = DEF_DWELL_CYC
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid_i,
  input  logic           req_sel_i,
  output logic           req_ready_o,
  output logic           select_o,
  output logic           cur_sel_o,
  output logic           busy_o,
  output logic           done_o,
`ifdef CLK_SEL_SWITCH_CNT_EN
  output logic [CNT_W-1:0] switch_cnt_o,
`endif
  output clk_sel_state_e dbg_state_o
);

  localparam int TMR_W = timer_width(SETTLE_CYC, DWELL_CYC);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] DWELL_LOAD  = TMR_W'((DWELL_CYC > 0) ? DWELL_CYC - 1 : 0);
  localparam bit HAS_DWELL = (DWELL_CYC > 0);

  clk_sel_state_e   state_q;
  logic             select_q;
  logic             cur_sel_q;
  logic             req_ready_q;
  logic             done_q;

  logic             accept;
  logic             start_switch;
  logic             settle_end;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_load_val;
  logic             tmr_dec;
  logic             tmr_zero;

  assign accept       = req_valid_i & req_ready_q;
  assign start_switch = (state_q == IDLE) & accept & (req_sel_i != cur_sel_q);
  assign settle_end   = (state_q == SETTLE) & tmr_zero;
  assign tmr_dec      = (state_q != IDLE);

  // Timer loads: settle length on a new switch, dwell length when settle ends.
  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = SETTLE_LOAD;
    if (start_switch) begin
      tmr_load     = 1'b1;
      tmr_load_val = SETTLE_LOAD;
    end else if (settle_end && HAS_DWELL) begin
      tmr_load     = 1'b1;
      tmr_load_val = DWELL_LOAD;
    end
  end

  clk_sel_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // Control FSM with registered select, confirmation, ready and done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      select_q    <= 1'b0;
      cur_sel_q   <= 1'b0;
      req_ready_q <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (req_sel_i != cur_sel_q) begin
              select_q    <= req_sel_i;
              req_ready_q <= 1'b0;
              state_q     <= SETTLE;
            end else begin
              // Already on the requested source: complete without a switch.
              done_q <= 1'b1;
            end
          end
        end
        SETTLE: begin
          if (tmr_zero) begin
            done_q    <= 1'b1;
            cur_sel_q <= select_q;
            if (HAS_DWELL) begin
              state_q <= DWELL;
            end else begin
              state_q     <= IDLE;
              req_ready_q <= 1'b1;
            end
          end
        end
        DWELL: begin
          if (tmr_zero) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef CLK_SEL_SWITCH_CNT_EN
  logic [CNT_W-1:0] switch_cnt_q;

  // Saturating count of completed real switches (same-source requests excluded).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      switch_cnt_q <= '0;
    end else if (settle_end && (switch_cnt_q != '1)) begin
      switch_cnt_q <= switch_cnt_q + CNT_W'(1);
    end
  end

  assign switch_cnt_o = switch_cnt_q;
`endif

  assign req_ready_o = req_ready_q;
  assign select_o    = select_q;
  assign cur_sel_o   = cur_sel_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Directed bench for clk_sel_ctrl: default-parameter instance, a fast
// instance (SETTLE_CYC=1, DWELL_CYC=0) and, with CLK_SEL_SWITCH_CNT_EN,
// a 2-bit switch-counter instance.
module tb_clk_sel_ctrl;
  import clk_sel_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic req_valid = 1'b0, req_sel = 1'b0;
  logic req_ready, select_s, cur_sel, busy, done;
  clk_sel_state_e state;

  logic f_valid = 1'b0, f_sel = 1'b0;
  logic f_ready, f_select, f_cur_sel, f_busy, f_done;
  clk_sel_state_e f_state;

`ifdef CLK_SEL_SWITCH_CNT_EN
  logic [7:0] sw_cnt;
  logic [7:0] f_cnt;
  logic c_valid = 1'b0, c_sel = 1'b0;
  logic c_ready, c_select, c_cur_sel, c_busy, c_done;
  logic [1:0] c_cnt;
  clk_sel_state_e c_state;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  clk_sel_ctrl u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_sel_i    (req_sel),
    .req_ready_o  (req_ready),
    .select_o     (select_s),
    .cur_sel_o    (cur_sel),
    .busy_o       (busy),
    .done_o       (done),
`ifdef CLK_SEL_SWITCH_CNT_EN
    .switch_cnt_o (sw_cnt),
`endif
    .dbg_state_o  (state)
  );

  clk_sel_ctrl #(
    .SETTLE_CYC (1),
    .DWELL_CYC  (0)
  ) u_fast (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (f_valid),
    .req_sel_i    (f_sel),
    .req_ready_o  (f_ready),
    .select_o     (f_select),
    .cur_sel_o    (f_cur_sel),
    .busy_o       (f_busy),
    .done_o       (f_done),
`ifdef CLK_SEL_SWITCH_CNT_EN
    .switch_cnt_o (f_cnt),
`endif
    .dbg_state_o  (f_state)
  );

`ifdef CLK_SEL_SWITCH_CNT_EN
  clk_sel_ctrl #(
    .CNT_W      (2),
    .SETTLE_CYC (2),
    .DWELL_CYC  (1)
  ) u_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (c_valid),
    .req_sel_i    (c_sel),
    .req_ready_o  (c_ready),
    .select_o     (c_select),
    .cur_sel_o    (c_cur_sel),
    .busy_o       (c_busy),
    .done_o       (c_done),
    .switch_cnt_o (c_cnt),
    .dbg_state_o  (c_state)
  );
`endif

  // ---------------- driver tasks ----------------
  // One active edge, then land on the following falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    req_valid = 1'b0; req_sel = 1'b0;
    f_valid   = 1'b0; f_sel   = 1'b0;
`ifdef CLK_SEL_SWITCH_CNT_EN
    c_valid   = 1'b0; c_sel   = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [6:0] obs;
    logic [6:0] exp;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp = {IDLE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    obs = {state, select_s, cur_sel, req_ready, busy, done};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_in got %b want %b", obs, exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    obs = {state, select_s, cur_sel, req_ready, busy, done};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_after got %b want %b", obs, exp);
    end
`ifdef CLK_SEL_SWITCH_CNT_EN
    n_checks++;
    if (sw_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_switch_cnt got %0d want 0", sw_cnt);
    end
`endif
  endtask

  // Single switch to clk1; k counts edges after the acceptance edge E0.
  task automatic test_single_switch();
    logic [6:0] obs;
    logic [6:0] exp;
    clk_sel_state_e st;
    apply_reset();
    req_sel = 1'b1; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    req_sel   = 1'b0;
    for (int k = 0; k <= 30; k++) begin
      if (k > 0) step();
      st  = (k < 8) ? SETTLE : ((k < 24) ? DWELL : IDLE);
      exp = {st, 1'b1, (k >= 8), (k >= 24), (k < 24), (k == 8)};
      obs = {state, select_s, cur_sel, req_ready, busy, done};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL single_switch k=%0d got %b want %b", k, obs, exp);
      end
    end
  endtask

  // Same-source requests: done next cycle, no handshake drop, one done each.
  task automatic test_same_sel();
    logic [6:0] obs;
    logic [6:0] exp;
    apply_reset();
    req_sel = 1'b0; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) step();
      exp = {IDLE, 1'b0, 1'b0, 1'b1, 1'b0, (k == 0)};
      obs = {state, select_s, cur_sel, req_ready, busy, done};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL same_sel k=%0d got %b want %b", k, obs, exp);
      end
    end
    req_valid = 1'b1;
    for (int j = 0; j <= 3; j++) begin
      if (j == 3) req_valid = 1'b0;
      step();
      exp = {IDLE, 1'b0, 1'b0, 1'b1, 1'b0, (j < 3)};
      obs = {state, select_s, cur_sel, req_ready, busy, done};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL back_to_back_same j=%0d got %b want %b", j, obs, exp);
      end
    end
  endtask

  // Switch to 1, then hold a request for 0 through settle and dwell.
  task automatic test_back_to_back();
    logic [6:0] obs;
    logic [6:0] exp;
    logic       prev_sel;
    int         toggles;
    logic       rdy;
    clk_sel_state_e st;
    apply_reset();
    prev_sel = select_s;
    toggles  = 0;
    req_sel = 1'b1; req_valid = 1'b1;
    step();
    req_sel = 1'b0;
    for (int k = 0; k <= 55; k++) begin
      if (k > 0) step();
      if (select_s !== prev_sel) toggles++;
      prev_sel = select_s;
      rdy = (k == 24) || (k >= 49);
      if (k < 8)        st = SETTLE;
      else if (k < 24)  st = DWELL;
      else if (k == 24) st = IDLE;
      else if (k < 33)  st = SETTLE;
      else if (k < 49)  st = DWELL;
      else              st = IDLE;
      exp = {st, (k < 25), (k >= 8 && k < 33), rdy, !rdy, (k == 8 || k == 33)};
      obs = {state, select_s, cur_sel, req_ready, busy, done};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL held_request k=%0d got %b want %b", k, obs, exp);
      end
      if (k >= 25) req_valid = 1'b0;
    end
    n_checks++;
    if (toggles != 2) begin
      n_fail++;
      $display("FAIL select_toggles got %0d want 2", toggles);
    end
  endtask

  // Asynchronous reset in the middle of SETTLE and on the done cycle in DWELL.
  task automatic test_reset_mid();
    logic [6:0] obs;
    logic [6:0] exp;
    logic [6:0] idle_v;
    idle_v = {IDLE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int sc = 0; sc < 2; sc++) begin
      apply_reset();
      req_sel = 1'b1; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      repeat ((sc == 0) ? 4 : 8) step();
      exp = (sc == 0) ? {SETTLE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}
                      : {DWELL,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      obs = {state, select_s, cur_sel, req_ready, busy, done};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL pre_reset sc=%0d got %b want %b", sc, obs, exp);
      end
      rst_n = 1'b0;
      #1;
      obs = {state, select_s, cur_sel, req_ready, busy, done};
      n_checks++;
      if (obs !== idle_v) begin
        n_fail++;
        $display("FAIL async_reset sc=%0d got %b want %b", sc, obs, idle_v);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
        step();
        obs = {state, select_s, cur_sel, req_ready, busy, done};
        n_checks++;
        if (obs !== idle_v) begin
          n_fail++;
          $display("FAIL post_reset sc=%0d k=%0d got %b want %b", sc, k, obs, idle_v);
        end
      end
    end
  endtask

  // Fast instance: done right after E0, ready with done, back-to-back switch.
  task automatic test_no_dwell();
    logic [6:0] obs;
    logic [6:0] exp [0:4];
    apply_reset();
    exp[0] = {SETTLE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp[1] = {IDLE,   1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    exp[2] = {SETTLE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp[3] = {IDLE,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp[4] = {IDLE,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    f_sel = 1'b1; f_valid = 1'b1;
    step();
    f_sel = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) step();
      obs = {f_state, f_select, f_cur_sel, f_ready, f_busy, f_done};
      n_checks++;
      if (obs !== exp[k]) begin
        n_fail++;
        $display("FAIL no_dwell k=%0d got %b want %b", k, obs, exp[k]);
      end
      if (k >= 2) f_valid = 1'b0;
    end
`ifdef CLK_SEL_SWITCH_CNT_EN
    n_checks++;
    if (f_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL no_dwell_switch_cnt got %0d want 2", f_cnt);
    end
`endif
  endtask

`ifdef CLK_SEL_SWITCH_CNT_EN
  task automatic cnt_request(input logic sel, input logic [1:0] exp_cnt, input int idx);
    int waited;
    waited = 0;
    while (c_ready !== 1'b1 && waited < 50) begin
      step();
      waited++;
    end
    c_sel = sel; c_valid = 1'b1;
    step();
    c_valid = 1'b0;
    waited = 0;
    while (c_done !== 1'b1 && waited < 50) begin
      step();
      waited++;
    end
    n_checks++;
    if (c_done !== 1'b1 || c_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL switch_cnt req=%0d done=%b got %0d want %0d", idx, c_done, c_cnt, exp_cnt);
    end
  endtask

  task automatic test_switch_cnt();
    logic       sels [0:6];
    logic [1:0] exps [0:6];
    apply_reset();
    sels[0] = 1'b1; exps[0] = 2'd1;
    sels[1] = 1'b1; exps[1] = 2'd1;
    sels[2] = 1'b0; exps[2] = 2'd2;
    sels[3] = 1'b0; exps[3] = 2'd2;
    sels[4] = 1'b1; exps[4] = 2'd3;
    sels[5] = 1'b0; exps[5] = 2'd3;
    sels[6] = 1'b1; exps[6] = 2'd3;
    for (int i = 0; i < 7; i++) cnt_request(sels[i], exps[i], i);
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_switch();
    test_same_sel();
    test_back_to_back();
    test_reset_mid();
    test_no_dwell();
`ifdef CLK_SEL_SWITCH_CNT_EN
    test_switch_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
